// File: rtl/capture_pkg.sv
// Shared types and sizes for the serial capture path.
package capture_pkg;

    localparam int WORD_W    = 32;
    localparam int CNT_W     = 16;
    localparam int BIT_CNT_W = $clog2(WORD_W) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        SHIFT = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4
    } capture_state_t;

endpackage

// File: rtl/capture_unit_if.sv
// Write-FIFO push port: the capture unit is master, the FIFO is slave.
interface capture_unit_if #(
    parameter int WORD_W = capture_pkg::WORD_W
);

    logic [WORD_W-1:0] sendData;
    logic              pulseWrite;
    logic              fifoFull;

    modport master (output sendData, output pulseWrite, input fifoFull);
    modport slave  (input sendData, input pulseWrite, output fifoFull);

endinterface

// File: rtl/capture_unit_sync_edge.sv
// N-bit two-flop synchronizer with a one-cycle rising-edge pulse on bit 0.
module sync_edge #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic [N-1:0] d,
    output logic [N-1:1] q,
    output logic         rise
);

    logic [N-1:0] meta_p0;
    logic [N-1:0] sync_p1;
    logic         prev_p2;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= d;
            // stage 1 -> stage 2 -> edge history
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1[0];
        end
    end

    assign q    = sync_p1[N-1:1];
    assign rise = sync_p1[0] & ~prev_p2;

endmodule

// File: rtl/capture_unit.sv
// Serial-to-parallel capture: packs qualified bits MSB-first into words and pushes them to the write FIFO.
module capture_unit
    import capture_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             enable,
    input  logic [CNT_W-1:0] captureNum,
    input  logic             sampleClk,
    input  logic             dIn,
    input  logic             dEnable,
    capture_unit_if.master   wr,
    output logic             complete,
    output logic             overflow
);

    capture_state_t         state;
    logic [WORD_W-1:0]      shreg;
    logic [WORD_W-1:0]      word_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]       word_cnt;
    logic [CNT_W-1:0]       word_next;
    logic [CNT_W-1:0]       target;
    logic [2:1]             sync_q;
    logic                   strobe;
    logic                   sample;
    logic                   push_ok;

    sync_edge #(.N(3)) u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d      ({dEnable, dIn, sampleClk}),
        .q      (sync_q),
        .rise   (strobe)
    );

    assign sample    = strobe & sync_q[2];
    assign word_next = word_cnt + 1'b1;

    // The push is presented in the PUSH cycle itself; a falling enable suppresses it.
    assign push_ok       = (state == PUSH) & enable & ~wr.fifoFull;
    assign wr.pulseWrite = push_ok;
    assign wr.sendData   = push_ok ? shreg : word_q;
    assign complete      = (state == DONE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            shreg    <= '0;
            word_q   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            target   <= '0;
            overflow <= 1'b0;
        end else if (!enable) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= ARMED;
                    target   <= captureNum;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    overflow <= 1'b0;
                end
                ARMED: begin
                    if (target == '0) begin
                        state <= DONE;
                    end else if (sample) begin
                        shreg   <= {shreg[WORD_W-2:0], sync_q[1]};
                        bit_cnt <= BIT_CNT_W'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sample) begin
                        shreg   <= {shreg[WORD_W-2:0], sync_q[1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(WORD_W - 1)) begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    // A full FIFO drops the word but it still counts toward the request.
                    if (wr.fifoFull) begin
                        overflow <= 1'b1;
                    end else begin
                        word_q <= shreg;
                    end
                    word_cnt <= word_next;
                    bit_cnt  <= '0;
                    state    <= (word_next == target) ? DONE : SHIFT;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_unit.sv
// Directed bench for capture_unit: serial stimulus against a queue model of expected pushes.
module tb_capture_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic [15:0] captureNum;
    logic        sampleClk;
    logic        dIn;
    logic        dEnable;
    logic        complete;
    logic        overflow;

    capture_unit_if bus ();

    capture_unit dut (
        .clk        (clk),
        .resetN     (resetN),
        .enable     (enable),
        .captureNum (captureNum),
        .sampleClk  (sampleClk),
        .dIn        (dIn),
        .dEnable    (dEnable),
        .wr         (bus),
        .complete   (complete),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          pushes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_log[$];
    logic        pw_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Every push must be one cycle wide and carry the next word the model expects.
    always @(negedge clk) begin
        if (resetN) begin
            if (bus.pulseWrite) begin
                pushes++;
                got_log.push_back(bus.sendData);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL push_unexpected got=%h expected=no push", bus.sendData);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.sendData !== e) begin
                        miscompares++;
                        $display("FAIL push_word got=%h expected=%h", bus.sendData, e);
                    end
                end
                vectors++;
                if (pw_prev) begin
                    miscompares++;
                    $display("FAIL push_width got=2+ cycles expected=1 cycle");
                end
            end
            pw_prev = bus.pulseWrite;
        end else begin
            pw_prev = 1'b0;
        end
    end

    task automatic idle(input int n);
        sampleClk = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic en);
        sampleClk = 1'b0;
        dIn       = b;
        dEnable   = en;
        repeat (3) @(negedge clk);
        sampleClk = 1'b1;
        repeat (3) @(negedge clk);
        sampleClk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[31-i], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit dropped);
        if (!dropped) exp_q.push_back(w);
        send_bits(w, 32);
    endtask

    task automatic send_gap_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int i = 0; i < 16; i++) send_bit(w[31-i], 1'b1);
        for (int g = 0; g < 5; g++) send_bit(1'($urandom_range(1)), 1'b0);
        for (int i = 16; i < 32; i++) send_bit(w[31-i], 1'b1);
    endtask

    task automatic wait_complete(input string name);
        for (int i = 0; i < 60; i++) begin
            if (complete) break;
            @(negedge clk);
        end
        chk(name, 32'(complete), 32'd1);
    endtask

    logic [31:0] loop_words [8] = '{32'h6F3B2A1C, 32'h12345678, 32'hEABC9724, 32'h33333333,
                                    32'h456789AB, 32'hBB1BB1BB, 32'h1BBBBBB1, 32'h0F0F0F0F};
    int base;

    initial begin
        resetN     = 1'b0;
        enable     = 1'b0;
        captureNum = 16'd0;
        sampleClk  = 1'b0;
        dIn        = 1'b0;
        dEnable    = 1'b0;
        bus.fifoFull = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sendData", bus.sendData, 32'h0);
        chk("rst_pulseWrite", 32'(bus.pulseWrite), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        resetN = 1'b1;
        idle(2);

        // loopback of eight words
        base = pushes;
        captureNum = 16'd8;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) send_word(loop_words[i], 1'b0);
        wait_complete("loop_complete");
        chk("loop_pushes", 32'(pushes - base), 32'd8);
        chk("loop_overflow", 32'(overflow), 32'd0);
        chk("loop_first_word", got_log[base], 32'h6F3B2A1C);
        chk("loop_last_word", got_log[base + 7], 32'h0F0F0F0F);
        chk("loop_hold_sendData", bus.sendData, 32'h0F0F0F0F);
        enable = 1'b0;
        idle(3);
        chk("loop_complete_clear", 32'(complete), 32'd0);

        // gaps in the middle of a word
        base = pushes;
        captureNum = 16'd1;
        enable = 1'b1;
        send_gap_word(32'hA5A5A5A5);
        wait_complete("gap_complete");
        chk("gap_pushes", 32'(pushes - base), 32'd1);
        chk("gap_word", got_log[base], 32'hA5A5A5A5);
        enable = 1'b0;
        idle(3);

        // full FIFO during the second of three words
        base = pushes;
        captureNum = 16'd3;
        enable = 1'b1;
        send_word(32'hDEADBEEF, 1'b0);
        idle(4);
        bus.fifoFull = 1'b1;
        send_word(32'h0BADF00D, 1'b1);
        idle(4);
        bus.fifoFull = 1'b0;
        chk("full_overflow_set", 32'(overflow), 32'd1);
        chk("full_sendData_held", bus.sendData, 32'hDEADBEEF);
        send_word(32'h80000001, 1'b0);
        wait_complete("full_complete");
        chk("full_pushes", 32'(pushes - base), 32'd2);
        chk("full_overflow_end", 32'(overflow), 32'd1);
        chk("full_last_word", got_log[base + 1], 32'h80000001);
        enable = 1'b0;
        idle(3);
        chk("full_overflow_idle", 32'(overflow), 32'd0);

        // zero-word request
        base = pushes;
        captureNum = 16'd0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("zero_complete", 32'(complete), 32'd1);
        idle(10);
        chk("zero_pushes", 32'(pushes - base), 32'd0);
        enable = 1'b0;
        idle(3);

        // abort after 17 bits of word 2, then a fresh single-word capture
        base = pushes;
        captureNum = 16'd2;
        enable = 1'b1;
        bus.fifoFull = 1'b1;
        send_word(32'hC0FFEE11, 1'b1);
        idle(4);
        bus.fifoFull = 1'b0;
        chk("abort_overflow_set", 32'(overflow), 32'd1);
        send_bits(32'h5A5A0F0F, 17);
        enable = 1'b0;
        idle(12);
        chk("abort_pushes", 32'(pushes - base), 32'd0);
        chk("abort_complete", 32'(complete), 32'd0);
        captureNum = 16'd1;
        enable = 1'b1;
        idle(2);
        chk("rearm_overflow", 32'(overflow), 32'd0);
        send_word(32'h89ABCDEF, 1'b0);
        wait_complete("rearm_complete");
        chk("rearm_pushes", 32'(pushes - base), 32'd1);
        chk("rearm_word", got_log[base], 32'h89ABCDEF);
        enable = 1'b0;
        idle(3);

        // asynchronous reset in the middle of a word
        base = pushes;
        captureNum = 16'd2;
        enable = 1'b1;
        send_word(32'h13579BDF, 1'b0);
        idle(4);
        chk("rst_mid_before", bus.sendData, 32'h13579BDF);
        send_bits(32'h2468ACE0, 10);
        #3;
        resetN = 1'b0;
        #1;
        chk("rst_mid_sendData", bus.sendData, 32'h0);
        chk("rst_mid_pulseWrite", 32'(bus.pulseWrite), 32'd0);
        chk("rst_mid_complete", 32'(complete), 32'd0);
        chk("rst_mid_overflow", 32'(overflow), 32'd0);
        captureNum = 16'd1;
        idle(3);
        resetN = 1'b1;
        idle(3);
        send_word(32'hFEDCBA98, 1'b0);
        wait_complete("rst_restart_complete");
        chk("rst_restart_pushes", 32'(pushes - base), 32'd2);
        chk("rst_restart_word", got_log[base + 1], 32'hFEDCBA98);
        enable = 1'b0;
        idle(3);

        chk("model_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
